// File: rtl/tt_sweep_capture_pkg.sv
// Shared types and sizing for the truth-table sweep/capture harness.
package tt_sweep_capture_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDrain
  } state_e;

  localparam int unsigned N_IN_DEF   = 8;
  localparam int unsigned WORD_DEF   = 32;
  localparam int unsigned N_MINTERMS = 2 ** N_IN_DEF;
  localparam int unsigned N_WORDS    = N_MINTERMS / WORD_DEF;

  function automatic int unsigned idx_width(input int unsigned word);
    return $clog2(word);
  endfunction

endpackage

// File: rtl/tt_word_packer.sv
// Packs one sample per cycle into a word and holds completed words in a
// single-entry valid/ready output buffer.
module tt_word_packer #(
  parameter int unsigned WORD  = 32,
  parameter int unsigned IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample,
  input  logic             y,
  input  logic [IDX_W-1:0] idx,
  input  logic             last,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WORD-1:0]  out_data,
  output logic             out_last
);

  logic [WORD-2:0] pack_q, pack_d;
  logic [WORD-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            word_end;
  logic            accept;

  assign word_end = (idx == IDX_W'(WORD - 1));
  assign accept   = valid_q && out_ready;

  always_comb begin
    pack_d  = pack_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (accept) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
    // A completing sample overrides the accept so the buffer refills with no bubble.
    if (sample) begin
      if (word_end) begin
        data_d  = {y, pack_q};
        valid_d = 1'b1;
        last_d  = last;
      end else begin
        pack_d[idx] = y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pack_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      pack_q  <= pack_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps all input minterms of a combinational function, samples its output
// and streams the resulting truth table as packed words.
module tt_sweep_capture
  import tt_sweep_capture_pkg::*;
#(
  parameter int unsigned N_IN = N_IN_DEF,
  parameter int unsigned WORD = WORD_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic [N_IN-1:0] x,
  input  logic            y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] out_data,
  output logic            out_last,
  output logic [N_IN:0]   ones_count,
  output logic            done
);

  localparam int unsigned IDX_W = idx_width(WORD);

  state_e           state_q, state_d;
  logic [N_IN-1:0]  x_q, x_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_IN:0]    ones_q, ones_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             word_end;
  logic             stall;
  logic             last_x;
  logic             sample;

  assign word_end = (idx_q == IDX_W'(WORD - 1));
  // Only a word-completing sample needs the buffer free.
  assign stall    = word_end && out_valid && !out_ready;
  assign last_x   = (x_q == {N_IN{1'b1}});
  assign sample   = (state_q == StSweep) && !stall;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    idx_d   = idx_q;
    ones_d  = ones_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          x_d     = '0;
          idx_d   = '0;
          ones_d  = '0;
          busy_d  = 1'b1;
          state_d = StSweep;
        end
      end
      StSweep: begin
        if (sample) begin
          ones_d = ones_q + {{N_IN{1'b0}}, y};
          idx_d  = word_end ? '0 : idx_q + 1'b1;
          if (last_x) begin
            state_d = StDrain;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (out_valid && out_ready) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      idx_q   <= '0;
      ones_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      idx_q   <= idx_d;
      ones_q  <= ones_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  tt_word_packer #(
    .WORD  (WORD),
    .IDX_W (IDX_W)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .sample    (sample),
    .y         (y),
    .idx       (idx_q),
    .last      (last_x),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  assign x          = x_q;
  assign busy       = busy_q;
  assign ones_count = ones_q;
  assign done       = done_q;

endmodule
